// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM/owner encodings and counter widths for mem_port_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {FETCH, DATA} owner_t;
  // Latency counter is sized for the largest legal MEM_LAT (8).
  localparam int MEM_LAT_MAX = 8;
  localparam int LAT_W = $clog2(MEM_LAT_MAX + 1);
  // Starvation counter holds STARVE_MAX up to 15.
  localparam int STARVE_W = 4;
endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating count of data grants made while a fetch waits
// ports: clk, reset (sync, high), clr, inc -> at_max (count == MAX)
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_max
);
  logic [STARVE_W-1:0] cnt;
  assign at_max = cnt == STARVE_W'(MAX);
  always_ff @(posedge clk)
    if (reset | clr) cnt <= '0;
    else if (inc & ~at_max) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port memory arbiter between instruction fetch and MEM-stage data
// ports: if_* fetch side, dm_* data side, mem_* memory command/read data, stall_if/stall_mem to hazard unit
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);
  state_t state, state_nx;
  owner_t owner;
  logic [LAT_W-1:0] lat_cnt;
  logic [DATA_W-1:0] rdata_q;
  logic cancel_q, at_max, idle, resp, grant_fetch, grant_data;
  // Command outputs are forced quiet while reset is held.
  assign idle = (state == IDLE) & ~reset;
  assign resp = (state == RESP) & ~reset;
  assign grant_fetch = idle & if_req & ~if_cancel & (~dm_req | at_max);
  assign grant_data = idle & dm_req & ~grant_fetch;
  arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
    .clk(clk),
    .reset(reset),
    .clr(grant_fetch | ~if_req),
    .inc(grant_data & if_req),
    .at_max(at_max)
  );
  // Stores skip BUSY: the write lands in the issue cycle, so RESP follows at once.
  always_comb begin
    mem_en = grant_fetch | grant_data;
    mem_we = grant_data & dm_we;
    mem_addr = grant_data ? dm_addr : grant_fetch ? if_addr : '0;
    mem_wdata = mem_we ? dm_wdata : '0;
    state_nx = state == RESP ? IDLE
             : state == BUSY ? (lat_cnt == LAT_W'(1) ? RESP : BUSY)
             : mem_we ? RESP : mem_en ? BUSY : IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      owner <= FETCH;
      lat_cnt <= '0;
      rdata_q <= '0;
      cancel_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (mem_en) begin
        owner <= grant_data ? DATA : FETCH;
        lat_cnt <= LAT_W'(MEM_LAT);
        rdata_q <= '0;
        cancel_q <= 1'b0;
      end
      if (state == BUSY) begin
        lat_cnt <= lat_cnt - 1'b1;
        if (lat_cnt == LAT_W'(1)) rdata_q <= mem_rdata;
      end
      if (state != IDLE && owner == FETCH && if_cancel) cancel_q <= 1'b1;
    end
  assign if_ready = resp & (owner == FETCH) & ~cancel_q & ~if_cancel;
  assign dm_ready = resp & (owner == DATA);
  assign if_rdata = if_ready ? rdata_q : '0;
  assign dm_rdata = dm_ready ? rdata_q : '0;
  assign stall_if = if_req & ~if_ready & ~if_cancel;
  assign stall_mem = dm_req & ~dm_ready;
endmodule
